// File: rtl/cache_axi_arbiter.sv
// cache_axi_arbiter: shares one memory read port between icache and dcache, forwards dcache writes.
// Define ARB_ROUND_ROBIN_EN for round-robin read arbitration (default: dcache has fixed priority).
module cache_axi_arbiter #(
   parameter int LINE_OFS_W = 4
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         ic_rd_req,
   input  logic [2:0]   ic_rd_type,
   input  logic [31:0]  ic_rd_addr,
   output logic         ic_rd_rdy,
   output logic         ic_ret_valid,
   output logic         ic_ret_last,
   output logic [31:0]  ic_ret_data,
   input  logic         dc_rd_req,
   input  logic [2:0]   dc_rd_type,
   input  logic [31:0]  dc_rd_addr,
   output logic         dc_rd_rdy,
   output logic         dc_ret_valid,
   output logic         dc_ret_last,
   output logic [31:0]  dc_ret_data,
   input  logic         dc_wr_req,
   input  logic [2:0]   dc_wr_type,
   input  logic [31:0]  dc_wr_addr,
   input  logic [3:0]   dc_wr_wstrb,
   input  logic [127:0] dc_wr_data,
   output logic         dc_wr_rdy,
   output logic         dc_data_write_ok,
   output logic         m_rd_req,
   output logic [2:0]   m_rd_type,
   output logic [31:0]  m_rd_addr,
   input  logic         m_rd_rdy,
   input  logic         m_ret_valid,
   input  logic         m_ret_last,
   input  logic [31:0]  m_ret_data,
   output logic         m_wr_req,
   output logic [2:0]   m_wr_type,
   output logic [31:0]  m_wr_addr,
   output logic [3:0]   m_wr_wstrb,
   output logic [127:0] m_wr_data,
   input  logic         m_wr_rdy,
   input  logic         m_data_write_ok
);
   typedef enum logic [1:0] {R_IDLE, R_REQ, R_DATA} rstate_t;
   typedef enum logic {W_IDLE, W_BUSY} wstate_t;
   rstate_t rstate;
   wstate_t wstate;
   logic owner;
   logic [31-LINE_OFS_W:0] wline;
   logic own_req, hazard, rd_acc, wr_acc, winner, rd_ret, w_idle;
   logic [31:0] own_addr;
`ifdef ARB_ROUND_ROBIN_EN
   logic rr_last;
   assign winner = (ic_rd_req && dc_rd_req) ? ~rr_last : dc_rd_req;
`else
   assign winner = dc_rd_req;
`endif
   assign own_req   = owner ? dc_rd_req : ic_rd_req;
   assign own_addr  = owner ? dc_rd_addr : ic_rd_addr;
   assign m_rd_type = owner ? dc_rd_type : ic_rd_type;
   assign m_rd_addr = own_addr;
   assign w_idle    = resetn && wstate == W_IDLE;
   assign m_wr_req  = w_idle && dc_wr_req;
   assign dc_wr_rdy = w_idle && m_wr_rdy;
   assign wr_acc    = m_wr_req && m_wr_rdy;
   // Block reads to a line that is being written or is still in flight to memory
   assign hazard = (wstate == W_BUSY && own_addr[31:LINE_OFS_W] == wline) ||
                   (wr_acc && own_addr[31:LINE_OFS_W] == dc_wr_addr[31:LINE_OFS_W]);
   assign m_rd_req  = rstate == R_REQ && own_req && !hazard;
   assign rd_acc    = m_rd_req && m_rd_rdy;
   assign ic_rd_rdy = rd_acc && !owner;
   assign dc_rd_rdy = rd_acc && owner;
   assign rd_ret       = rstate == R_DATA;
   assign ic_ret_valid = rd_ret && !owner && m_ret_valid;
   assign ic_ret_last  = rd_ret && !owner && m_ret_last;
   assign ic_ret_data  = (rd_ret && !owner) ? m_ret_data : '0;
   assign dc_ret_valid = rd_ret && owner && m_ret_valid;
   assign dc_ret_last  = rd_ret && owner && m_ret_last;
   assign dc_ret_data  = (rd_ret && owner) ? m_ret_data : '0;
   assign m_wr_type  = dc_wr_type;
   assign m_wr_addr  = dc_wr_addr;
   assign m_wr_wstrb = dc_wr_wstrb;
   assign m_wr_data  = dc_wr_data;
   assign dc_data_write_ok = m_data_write_ok;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rstate <= R_IDLE;
         wstate <= W_IDLE;
         owner  <= 1'b0;
         wline  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         rr_last <= 1'b0;
`endif
      end else begin
         case (rstate)
            R_IDLE: if (ic_rd_req || dc_rd_req) begin
               owner  <= winner;
               rstate <= R_REQ;
            end
            R_REQ: rstate <= !own_req ? R_IDLE : rd_acc ? R_DATA : R_REQ;
            R_DATA: if (m_ret_valid && m_ret_last) rstate <= R_IDLE;
            default: rstate <= R_IDLE;
         endcase
`ifdef ARB_ROUND_ROBIN_EN
         if (rd_acc) rr_last <= owner;
`endif
         if (wr_acc) begin
            wline  <= dc_wr_addr[31:LINE_OFS_W];
            wstate <= W_BUSY;
         end else if (wstate == W_BUSY && m_data_write_ok) wstate <= W_IDLE;
      end
   end
endmodule

// File: doc/cache_axi_arbiter.md
CACHE_AXI_ARBITER -- requirements
Module: cache_axi_arbiter

Interface
REQ-001 SHALL have parameter LINE_OFS_W, default 4, meaning the number of low address bits ignored when comparing cache-line addresses.
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port resetn, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have icache read ports:
- ic_rd_req in 1; ic_rd_type in 3; ic_rd_addr in 32.
- ic_rd_rdy out 1; ic_ret_valid out 1; ic_ret_last out 1; ic_ret_data out 32.
REQ-005 SHALL have dcache read ports:
- dc_rd_req in 1; dc_rd_type in 3; dc_rd_addr in 32.
- dc_rd_rdy out 1; dc_ret_valid out 1; dc_ret_last out 1; dc_ret_data out 32.
REQ-006 SHALL have dcache write ports:
- dc_wr_req in 1; dc_wr_type in 3; dc_wr_addr in 32; dc_wr_wstrb in 4; dc_wr_data in 128.
- dc_wr_rdy out 1; dc_data_write_ok out 1.
REQ-007 SHALL have memory-side read ports:
- m_rd_req out 1; m_rd_type out 3; m_rd_addr out 32.
- m_rd_rdy in 1; m_ret_valid in 1; m_ret_last in 1; m_ret_data in 32.
REQ-008 SHALL have memory-side write ports:
- m_wr_req out 1; m_wr_type out 3; m_wr_addr out 32; m_wr_wstrb out 4; m_wr_data out 128.
- m_wr_rdy in 1; m_data_write_ok in 1.

Function
REQ-009 SHALL run a read FSM with states R_IDLE, R_REQ and R_DATA, plus a 1-bit owner register (0 = icache, 1 = dcache).
REQ-010 In R_IDLE, if any rd_req is high, the FSM SHALL latch the arbitration winner into owner and go to R_REQ next cycle; m_rd_req SHALL be 0 in R_IDLE (minimum one-cycle request-to-memory latency).
REQ-011 In R_REQ, m_rd_req SHALL be the owner's rd_req AND NOT hazard; m_rd_type and m_rd_addr SHALL be the owner's values.
REQ-012 A read SHALL be accepted in the cycle m_rd_req && m_rd_rdy; in that cycle the owner's rd_rdy SHALL be 1 and the FSM SHALL go to R_DATA. Rd_rdy SHALL be 0 at all other times.
REQ-013 If the owner's rd_req drops in R_REQ before acceptance, the FSM SHALL return to R_IDLE without issuing a read.
REQ-014 In R_DATA, m_ret_valid, m_ret_last and m_ret_data SHALL route combinationally to the owner only; the non-owner's ret_valid and ret_last SHALL be 0.
- m_ret_valid && m_ret_last SHALL return the FSM to R_IDLE.
- A request pending in that same cycle SHALL be arbitrated in the following R_IDLE cycle.
REQ-015 Exactly one read SHALL be outstanding at a time.
REQ-016 The write FSM SHALL have states W_IDLE and W_BUSY; only the dcache writes.
REQ-017 In W_IDLE:
- m_wr_* SHALL equal dc_wr_*.
- dc_wr_rdy SHALL equal m_wr_rdy.
- dc_wr_req && m_wr_rdy SHALL latch dc_wr_addr[31:LINE_OFS_W] into wline and go to W_BUSY.
REQ-018 In W_BUSY, m_wr_req and dc_wr_rdy SHALL be 0; m_data_write_ok SHALL return the FSM to W_IDLE.
REQ-019 dc_data_write_ok SHALL equal m_data_write_ok at all times.
REQ-020 Hazard SHALL be 1 when the owner's rd_addr[31:LINE_OFS_W] equals either of:
- wline, while in W_BUSY;
- dc_wr_addr[31:LINE_OFS_W], in a cycle where a write is being accepted.
REQ-021 When hazard is 1, the read SHALL be held in R_REQ; it SHALL be issued no earlier than the cycle after m_data_write_ok.
REQ-022 Read and write channels SHALL operate concurrently whenever no hazard exists.

Reset
REQ-023 Asserting resetn low SHALL immediately force R_IDLE, W_IDLE, owner = 0, wline = 0 and the round-robin pointer to "icache last".
REQ-024 During reset, all req, rdy, valid and last outputs SHALL be 0; returns or write-oks arriving mid-transaction SHALL be dropped.

Configuration
REQ-025 With macro ARB_ROUND_ROBIN_EN undefined, arbitration SHALL be fixed priority, dcache over icache.
REQ-026 With ARB_ROUND_ROBIN_EN defined:
- On simultaneous requests, the requester not granted last SHALL win.
- The pointer SHALL update on each read acceptance (REQ-012).
- After reset the pointer is "icache last", so the dcache wins the first tie.

Verification
REQ-027 Icache-only read: ic_rd_req with ic_rd_addr=0x1C000000, type 4; m_rd_rdy=1 -> m_rd_req asserted one cycle after the request; four m_ret beats go only to ic_*; dc_ret_valid stays 0.
REQ-028 Simultaneous ic and dc requests in back-to-back trials -> without the macro, the dcache wins both; with ARB_ROUND_ROBIN_EN, dcache then icache.
REQ-029 Hazard: write accepted to 0x00001230, then dc read of 0x0000123C -> m_rd_req stays 0 until the cycle after m_data_write_ok; a read of 0x00001240 issues immediately.
REQ-030 Overlap: write in W_BUSY while the icache reads a different line -> read completes during W_BUSY; dc_wr_rdy stays 0 until write-ok.
REQ-031 Reset pulse in R_DATA after two beats -> all outputs 0 asynchronously; after release, remaining beats are ignored and a new request proceeds from R_IDLE.
REQ-032 Owner drops rd_req in R_REQ with m_rd_rdy=0 -> FSM returns to R_IDLE and m_rd_req never pulses with the stale address.
